// File: rtl/wshb_ram_slave_if.sv
// Wishbone bus bundle shared by the RAM responder and whatever drives it.
//   cyc, stb, we        : cycle, strobe and write-enable from the master
//   sel[DATA_BYTES-1:0] : byte-lane enables
//   adr[31:0]           : byte address
//   dat_ms / dat_sm     : write data (master to slave) / read data (slave to master)
//   cti[2:0], bte[1:0]  : cycle-type and burst-type tags
//   ack, err, rty       : responder termination signals
interface wshb_if #(
   parameter int DATA_BYTES = 4
) ();

   logic                      cyc;
   logic                      stb;
   logic                      we;
   logic [DATA_BYTES-1:0]     sel;
   logic [31:0]               adr;
   logic [8*DATA_BYTES-1:0]   dat_ms;
   logic [8*DATA_BYTES-1:0]   dat_sm;
   logic [2:0]                cti;
   logic [1:0]                bte;
   logic                      ack;
   logic                      err;
   logic                      rty;

   modport slave (
      input  cyc, stb, we, sel, adr, dat_ms, cti, bte,
      output ack, err, rty, dat_sm
   );

   modport master (
      output cyc, stb, we, sel, adr, dat_ms, cti, bte,
      input  ack, err, rty, dat_sm
   );

endinterface

// File: rtl/wshb_ram_slave.sv
// Wishbone responder backed by a 2**ADDR_WIDTH x 32-bit RAM.
// Classic cycles are acknowledged WAIT_STATES+1 cycles after the request is
// first sampled; incrementing linear bursts (cti=010, bte=00) then stream one
// beat per cycle using a prefetched next word. Addresses above the RAM range
// are terminated with err instead of ack and never write.
//   sys_clk  : system clock, rising edge
//   sys_rst  : asynchronous active-high reset
//   wshb_ifs : Wishbone responder port (ack, err, dat_sm registered; rty tied 0)
//
// state | meaning
// IDLE  | no cycle in progress, waiting for cyc & stb
// WAIT  | counting wait states before the first response
// RESP  | first (or only) response cycle, ack/err high
// BURST | linear burst streaming, one beat per cycle while stb is high
module wshb_ram_slave #(
   parameter int ADDR_WIDTH  = 12,
   parameter int WAIT_STATES = 1
) (
   input  logic  sys_clk,
   input  logic  sys_rst,
   wshb_if.slave wshb_ifs
);

   localparam int                    DEPTH     = 2**ADDR_WIDTH;
   localparam logic [2:0]            WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
   localparam logic [ADDR_WIDTH-1:0] IDX_ONE   = ADDR_WIDTH'(1);
   localparam logic [2:0]            CTI_INCR  = 3'b010;

   typedef enum logic [1:0] {IDLE, WAIT, RESP, BURST} state_t;

   state_t                  state, state_next;
   logic [2:0]              cnt, cnt_next;
   logic [ADDR_WIDTH-1:0]   baddr, baddr_next;
   logic [ADDR_WIDTH-1:0]   idx, rd_idx;
   logic                    oor, oor_next;
   logic                    resp_next, load_rd;
   logic                    ack_r, err_r;
   logic [31:0]             dat_r;
   logic                    req, in_range, burst_ok, resp_r, beat_done, wr_en;
   logic                    unused_adr;

   logic [31:0]             mem [DEPTH];

   assign req       = wshb_ifs.cyc & wshb_ifs.stb;
   assign idx       = wshb_ifs.adr[ADDR_WIDTH+1:2];
   assign in_range  = (wshb_ifs.adr[31:ADDR_WIDTH+2] == '0);
   assign burst_ok  = (wshb_ifs.cti == CTI_INCR) && (wshb_ifs.bte == 2'b00);
   assign resp_r    = ack_r | err_r;
   // A response cycle only counts as a completed beat if the master still
   // holds the request through it.
   assign beat_done = resp_r & req;
   assign wr_en     = ack_r & req & wshb_ifs.we;
   assign unused_adr = &{1'b0, wshb_ifs.adr[1:0]};

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      baddr_next = baddr;
      oor_next   = oor;
      resp_next  = 1'b0;
      load_rd    = 1'b0;
      rd_idx     = idx;
      case (state)
         IDLE: begin
            if (req) begin
               oor_next = ~in_range;
               if (WAIT_STATES == 0) begin
                  state_next = RESP;
                  resp_next  = 1'b1;
                  load_rd    = 1'b1;
               end else begin
                  state_next = WAIT;
                  cnt_next   = WAIT_LOAD;
               end
            end
         end
         WAIT: begin
            if (!wshb_ifs.cyc) begin
               state_next = IDLE;
               cnt_next   = 3'd0;
            end else if (cnt != 3'd0) begin
               cnt_next = cnt - 3'd1;
            end else if (req) begin
               state_next = RESP;
               resp_next  = 1'b1;
               oor_next   = ~in_range;
               load_rd    = 1'b1;
            end
         end
         RESP: begin
            state_next = IDLE;
            if (beat_done && burst_ok) begin
               // Master presents the next beat only after this edge, so the
               // next word is fetched from our own incremented address.
               state_next = BURST;
               resp_next  = 1'b1;
               baddr_next = idx + IDX_ONE;
               rd_idx     = idx + IDX_ONE;
               load_rd    = 1'b1;
            end
         end
         BURST: begin
            if (!wshb_ifs.cyc) begin
               state_next = IDLE;
            end else if (beat_done) begin
               // Anything but another incrementing beat ends the burst.
               if (wshb_ifs.cti != CTI_INCR) begin
                  state_next = IDLE;
               end else begin
                  resp_next  = 1'b1;
                  baddr_next = baddr + IDX_ONE;
                  rd_idx     = baddr + IDX_ONE;
                  load_rd    = 1'b1;
               end
            end else if (!resp_r && wshb_ifs.stb) begin
               // Resume after a master wait: the pending beat is still baddr.
               resp_next = 1'b1;
               rd_idx    = baddr;
               load_rd   = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state <= IDLE;
         cnt   <= 3'd0;
         baddr <= '0;
         oor   <= 1'b0;
         ack_r <= 1'b0;
         err_r <= 1'b0;
         dat_r <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         baddr <= baddr_next;
         oor   <= oor_next;
         ack_r <= resp_next & ~oor_next;
         err_r <= resp_next & oor_next;
         if (load_rd) begin
            dat_r <= oor_next ? 32'd0 : mem[rd_idx];
         end
      end
   end

   // RAM has no reset; writes are gated by ack_r, which reset clears at once,
   // so a write pending when reset arrives is dropped.
   always_ff @(posedge sys_clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (wshb_ifs.sel[i]) begin
               mem[idx][8*i +: 8] <= wshb_ifs.dat_ms[8*i +: 8];
            end
         end
      end
   end

   assign wshb_ifs.ack    = ack_r;
   assign wshb_ifs.err    = err_r;
   assign wshb_ifs.rty    = 1'b0;
   assign wshb_ifs.dat_sm = dat_r;

endmodule

// File: tb/tb_wshb_ram_slave.sv
module tb_wshb_ram_slave;

   localparam int AW    = 12;
   localparam int WS    = 1;
   localparam int LAT   = WS + 1;
   localparam int DEPTH = 4096;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wshb_if #(.DATA_BYTES(4)) bus ();

   wshb_ram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
      .sys_clk  (clk),
      .sys_rst  (rst),
      .wshb_ifs (bus)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] mm [DEPTH];
   logic [31:0] beat_data [8];
   logic        beat_ack [8];
   int          r_lat;
   logic        r_ack, r_err, r_after;
   logic [31:0] r_data;

   function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] d,
                                              input logic [3:0] s);
      logic [31:0] res;
      res = old;
      for (int i = 0; i < 4; i++) if (s[i]) res[8*i +: 8] = d[8*i +: 8];
      return res;
   endfunction

   task automatic bus_idle();
      bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.sel = 4'h0;
      bus.adr = 32'h0; bus.dat_ms = 32'h0; bus.cti = 3'b000; bus.bte = 2'b00;
   endtask

   // One classic transfer; master releases the bus after sampling the response.
   task automatic bus_classic(input logic w, input logic [31:0] a, input logic [3:0] s,
                              input logic [31:0] d, input logic [2:0] c, input logic [1:0] b);
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = w; bus.adr = a; bus.sel = s;
      bus.dat_ms = d; bus.cti = c; bus.bte = b;
      r_lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (bus.ack || bus.err) begin r_lat = k; break; end
      end
      r_ack = bus.ack; r_err = bus.err; r_data = bus.dat_sm;
      @(posedge clk); #1;
      r_after = bus.ack | bus.err;
      bus_idle();
   endtask

   // Linear incrementing read burst of len beats starting at word start.
   task automatic bus_burst(input int start, input int len);
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.sel = 4'hF;
      bus.adr = 32'(start * 4); bus.cti = 3'b010; bus.bte = 2'b00;
      r_lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (bus.ack || bus.err) begin r_lat = k; break; end
      end
      for (int b = 0; b < len; b++) begin
         beat_ack[b]  = bus.ack & ~bus.err;
         beat_data[b] = bus.dat_sm;
         @(posedge clk); #1;
         if (b < len - 1) begin
            bus.adr = 32'(((start + b + 1) % DEPTH) * 4);
            bus.cti = (b + 1 == len - 1) ? 3'b111 : 3'b010;
         end
      end
      r_after = bus.ack | bus.err;
      bus_idle();
   endtask

   task automatic test_reset();
      bus_idle();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", bus.ack); end
      n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err); end
      n_checks++; if (bus.rty !== 1'b0) begin n_fail++; $display("FAIL reset_rty: got %b want 0", bus.rty); end
      n_checks++; if (bus.dat_sm !== 32'h0) begin n_fail++; $display("FAIL reset_dat: got %h want 0", bus.dat_sm); end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_classic();
      bus_classic(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 3'b000, 2'b00);
      mm[4] = lane_merge(mm[4], 32'hDEADBEEF, 4'hF);
      n_checks++; if ({r_ack, r_err} !== 2'b10) begin n_fail++; $display("FAIL classic_wr_ack: got ack/err %b%b want 10", r_ack, r_err); end
      n_checks++; if (r_lat !== LAT) begin n_fail++; $display("FAIL classic_wr_lat: got %0d want %0d", r_lat, LAT); end
      n_checks++; if (r_after !== 1'b0) begin n_fail++; $display("FAIL classic_wr_width: ack still high, got %b want 0", r_after); end
      bus_classic(1'b0, 32'h10, 4'h0, 32'h0, 3'b111, 2'b00);
      n_checks++; if (r_lat !== LAT) begin n_fail++; $display("FAIL classic_rd_lat: got %0d want %0d", r_lat, LAT); end
      n_checks++; if (r_data !== mm[4]) begin n_fail++; $display("FAIL classic_rd_data: got %h want %h", r_data, mm[4]); end
      n_checks++; if (bus.rty !== 1'b0) begin n_fail++; $display("FAIL classic_rty: got %b want 0", bus.rty); end
   endtask

   task automatic test_byte_lane();
      bus_classic(1'b1, 32'h10, 4'b0100, 32'h00AA0000, 3'b000, 2'b00);
      mm[4] = lane_merge(mm[4], 32'h00AA0000, 4'b0100);
      n_checks++; if (r_ack !== 1'b1) begin n_fail++; $display("FAIL lane_wr_ack: got %b want 1", r_ack); end
      bus_classic(1'b0, 32'h12, 4'hF, 32'h0, 3'b000, 2'b00);
      n_checks++; if (r_data !== mm[4]) begin n_fail++; $display("FAIL lane_rd_model: got %h want %h", r_data, mm[4]); end
      n_checks++; if (r_data !== 32'hDEAABEEF) begin n_fail++; $display("FAIL lane_rd_value: got %h want DEAABEEF", r_data); end
   endtask

   task automatic test_random_classic();
      logic [31:0] d, a;
      logic [3:0]  s;
      logic        w;
      logic [2:0]  c;
      logic [1:0]  b;
      int          widx, v;
      for (int i = 0; i < 70; i++) begin
         widx = (i < 64) ? i : (DEPTH - 70 + i);
         d = $urandom;
         bus_classic(1'b1, 32'(widx * 4), 4'hF, d, 3'b000, 2'b00);
         mm[widx] = d;
         n_checks++; if (r_ack !== 1'b1) begin n_fail++; $display("FAIL preload_ack[%0d]: got %b want 1", widx, r_ack); end
      end
      for (int i = 0; i < 40; i++) begin
         widx = $urandom_range(0, 63);
         a = 32'(widx * 4 + $urandom_range(0, 3));
         w = 1'($urandom_range(0, 1));
         s = 4'($urandom_range(0, 15));
         d = $urandom;
         v = $urandom_range(0, 3);
         case (v)
            0: begin c = 3'b000; b = 2'b00; end
            1: begin c = 3'b111; b = 2'($urandom_range(0, 3)); end
            2: begin c = 3'b001; b = 2'b00; end
            default: begin c = 3'b010; b = 2'($urandom_range(1, 3)); end
         endcase
         bus_classic(w, a, s, d, c, b);
         n_checks++; if ({r_ack, r_err} !== 2'b10) begin n_fail++; $display("FAIL rnd_ack[%0d]: got ack/err %b%b want 10", i, r_ack, r_err); end
         n_checks++; if (r_lat !== LAT) begin n_fail++; $display("FAIL rnd_lat[%0d]: got %0d want %0d", i, r_lat, LAT); end
         n_checks++; if (r_after !== 1'b0) begin n_fail++; $display("FAIL rnd_single[%0d]: cti=%b bte=%b resp after ack %b want 0", i, c, b, r_after); end
         if (w) begin
            mm[widx] = lane_merge(mm[widx], d, s);
         end else begin
            n_checks++; if (r_data !== mm[widx]) begin n_fail++; $display("FAIL rnd_rd[%0d]: word %0d got %h want %h", i, widx, r_data, mm[widx]); end
         end
      end
   endtask

   task automatic test_burst();
      int start, len;
      for (int i = 0; i < 4; i++) begin
         bus_classic(1'b1, 32'(i * 4), 4'hF, 32'(i + 1), 3'b000, 2'b00);
         mm[i] = 32'(i + 1);
      end
      bus_burst(0, 4);
      n_checks++; if (r_lat !== LAT) begin n_fail++; $display("FAIL burst4_lat: got %0d want %0d", r_lat, LAT); end
      for (int b = 0; b < 4; b++) begin
         n_checks++; if (beat_ack[b] !== 1'b1) begin n_fail++; $display("FAIL burst4_ack[%0d]: got %b want 1", b, beat_ack[b]); end
         n_checks++; if (beat_data[b] !== 32'(b + 1)) begin n_fail++; $display("FAIL burst4_data[%0d]: got %h want %h", b, beat_data[b], 32'(b + 1)); end
      end
      n_checks++; if (r_after !== 1'b0) begin n_fail++; $display("FAIL burst4_exit: got ack %b want 0", r_after); end
      bus_classic(1'b0, 32'h4, 4'hF, 32'h0, 3'b000, 2'b00);
      n_checks++; if (r_lat !== LAT) begin n_fail++; $display("FAIL burst4_idle_lat: got %0d want %0d", r_lat, LAT); end
      for (int r = 0; r < 6; r++) begin
         if (r == 0) begin start = DEPTH - 2; len = 4; end
         else begin
            start = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 58) : $urandom_range(DEPTH - 6, DEPTH - 1);
            len   = $urandom_range(2, 6);
         end
         bus_burst(start, len);
         n_checks++; if (r_lat !== LAT) begin n_fail++; $display("FAIL rburst_lat[%0d]: got %0d want %0d", r, r_lat, LAT); end
         for (int b = 0; b < len; b++) begin
            n_checks++;
            if (beat_ack[b] !== 1'b1 || beat_data[b] !== mm[(start + b) % DEPTH]) begin
               n_fail++;
               $display("FAIL rburst_beat[%0d.%0d]: word %0d got ack %b data %h want ack 1 data %h",
                        r, b, (start + b) % DEPTH, beat_ack[b], beat_data[b], mm[(start + b) % DEPTH]);
            end
         end
         n_checks++; if (r_after !== 1'b0) begin n_fail++; $display("FAIL rburst_exit[%0d]: got ack %b want 0", r, r_after); end
      end
   endtask

   task automatic test_out_of_range();
      bus_classic(1'b1, 32'h4000, 4'hF, ~mm[0], 3'b000, 2'b00);
      n_checks++; if ({r_ack, r_err} !== 2'b01) begin n_fail++; $display("FAIL oor_wr_resp: got ack/err %b%b want 01", r_ack, r_err); end
      n_checks++; if (r_lat !== LAT) begin n_fail++; $display("FAIL oor_wr_lat: got %0d want %0d", r_lat, LAT); end
      n_checks++; if (r_after !== 1'b0) begin n_fail++; $display("FAIL oor_wr_width: got %b want 0", r_after); end
      bus_classic(1'b0, 32'h0, 4'hF, 32'h0, 3'b000, 2'b00);
      n_checks++; if (r_data !== mm[0]) begin n_fail++; $display("FAIL oor_ram_kept: got %h want %h", r_data, mm[0]); end
      bus_classic(1'b0, 32'h8000_0010, 4'hF, 32'h0, 3'b000, 2'b00);
      n_checks++; if ({r_ack, r_err} !== 2'b01) begin n_fail++; $display("FAIL oor_rd_resp: got ack/err %b%b want 01", r_ack, r_err); end
      n_checks++; if (r_data !== 32'h0) begin n_fail++; $display("FAIL oor_rd_data: got %h want 0", r_data); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      int          k1, k2;
      d = $urandom;
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.adr = 32'd40; bus.sel = 4'hF;
      bus.dat_ms = d; bus.cti = 3'b000; bus.bte = 2'b00;
      k1 = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (bus.ack) begin k1 = k; break; end
      end
      n_checks++; if (k1 !== LAT) begin n_fail++; $display("FAIL b2b_first_lat: got %0d want %0d", k1, LAT); end
      @(posedge clk); #1;
      mm[10] = d;
      n_checks++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got ack %b want 0", bus.ack); end
      bus.we = 1'b0; bus.sel = 4'h0; bus.dat_ms = 32'h0;
      k2 = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (bus.ack) begin k2 = k; break; end
      end
      n_checks++; if (k2 !== LAT) begin n_fail++; $display("FAIL b2b_second_lat: got %0d want %0d", k2, LAT); end
      n_checks++; if (bus.dat_sm !== mm[10]) begin n_fail++; $display("FAIL b2b_data: got %h want %h", bus.dat_sm, mm[10]); end
      @(posedge clk); #1;
      bus_idle();
   endtask

   task automatic test_abort();
      logic seen;
      int   k1;
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.adr = 32'h80; bus.sel = 4'hF;
      bus.dat_ms = ~mm[32]; bus.cti = 3'b000; bus.bte = 2'b00;
      @(posedge clk); #1;
      bus_idle();
      seen = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         seen = seen | bus.ack | bus.err;
      end
      n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_wait_resp: got %b want 0", seen); end
      bus_classic(1'b0, 32'h80, 4'hF, 32'h0, 3'b000, 2'b00);
      n_checks++; if (r_lat !== LAT) begin n_fail++; $display("FAIL abort_wait_idle_lat: got %0d want %0d", r_lat, LAT); end
      n_checks++; if (r_data !== mm[32]) begin n_fail++; $display("FAIL abort_wait_nowrite: got %h want %h", r_data, mm[32]); end
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.adr = 32'h80; bus.sel = 4'hF;
      bus.dat_ms = ~mm[32];
      k1 = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (bus.ack) begin k1 = k; break; end
      end
      n_checks++; if (k1 !== LAT) begin n_fail++; $display("FAIL abort_resp_lat: got %0d want %0d", k1, LAT); end
      bus_idle();
      @(posedge clk); #1;
      n_checks++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL abort_resp_ack: got %b want 0", bus.ack); end
      bus_classic(1'b0, 32'h80, 4'hF, 32'h0, 3'b000, 2'b00);
      n_checks++; if (r_data !== mm[32]) begin n_fail++; $display("FAIL abort_resp_nowrite: got %h want %h", r_data, mm[32]); end
   endtask

   task automatic test_reset_burst();
      int k1;
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 32'h0; bus.sel = 4'hF;
      bus.cti = 3'b010; bus.bte = 2'b00;
      k1 = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (bus.ack) begin k1 = k; break; end
      end
      n_checks++; if (k1 !== LAT) begin n_fail++; $display("FAIL rstb_first_lat: got %0d want %0d", k1, LAT); end
      @(posedge clk); #1;
      bus.adr = 32'h4;
      n_checks++; if (bus.ack !== 1'b1) begin n_fail++; $display("FAIL rstb_beat1_ack: got %b want 1", bus.ack); end
      #3 rst = 1'b1;
      #1;
      n_checks++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL rstb_ack_clear: got %b want 0", bus.ack); end
      n_checks++; if (bus.dat_sm !== 32'h0) begin n_fail++; $display("FAIL rstb_dat_clear: got %h want 0", bus.dat_sm); end
      bus_idle();
      @(posedge clk); #1;
      rst = 1'b0;
      bus_classic(1'b0, 32'h8, 4'hF, 32'h0, 3'b000, 2'b00);
      n_checks++; if (r_lat !== LAT) begin n_fail++; $display("FAIL rstb_after_lat: got %0d want %0d", r_lat, LAT); end
      n_checks++; if (r_data !== mm[2]) begin n_fail++; $display("FAIL rstb_ram_kept: got %h want %h", r_data, mm[2]); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bus_idle();
      test_reset();
      test_classic();
      test_byte_lane();
      test_random_classic();
      test_burst();
      test_out_of_range();
      test_back_to_back();
      test_abort();
      test_reset_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
